// File: rtl/vc_mem_msg_pkg.sv
// vc_mem_msg_pkg: memory request type encodings and length decode shared by the SRAM port
package vc_mem_msg_pkg;
  localparam logic VC_MEM_REQ_READ  = 1'b0;
  localparam logic VC_MEM_REQ_WRITE = 1'b1;
  function automatic int len_to_nbytes(input int len, input int word_nbytes);
    return (len == 0) ? word_nbytes : len;
  endfunction
endpackage

// File: rtl/vc_sram_resp_queue_2entry.sv
// vc_sram_resp_queue_2entry: two-entry val/rdy FIFO holding {type, data} responses
module vc_sram_resp_queue_2entry #(
  parameter int p_msg_nbits = 33
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   full,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg
);
  logic [p_msg_nbits-1:0] entry [2];
  logic wr_ptr, rd_ptr, enq, deq;
  logic [1:0] count;
  assign full    = count == 2'd2;
  assign deq_val = count != 2'd0;
  assign enq     = enq_val && !full;
  assign deq     = deq_val && deq_rdy;
  assign deq_msg = entry[rd_ptr];
  always_ff @(posedge clk)
    if (enq) entry[wr_ptr] <= enq_msg;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) wr_ptr <= !wr_ptr;
      if (deq) rd_ptr <= !rd_ptr;
      count <= count + 2'(enq) - 2'(deq);
    end
endmodule

// File: rtl/vc_sram_mem_port.sv
// vc_sram_mem_port: val/rdy byte-addressed request front end driving a combinational 1rw SRAM
module vc_sram_mem_port
  import vc_mem_msg_pkg::*;
#(
  parameter int p_data_nbits  = 32,
  parameter int p_num_entries = 256,
  localparam int c_addr_nbits  = $clog2(p_num_entries),
  localparam int c_data_nbytes = p_data_nbits / 8,
  localparam int c_off_nbits   = $clog2(c_data_nbytes),
  localparam int c_baddr_nbits = c_addr_nbits + c_off_nbits
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sd,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic                     req_type,
  input  logic [c_baddr_nbits-1:0] req_addr,
  input  logic [c_off_nbits-1:0]   req_len,
  input  logic [p_data_nbits-1:0]  req_data,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic                     resp_type,
  output logic [p_data_nbits-1:0]  resp_data,
  output logic                     sram_read_en,
  output logic [c_addr_nbits-1:0]  sram_read_addr,
  input  logic [p_data_nbits-1:0]  sram_read_data,
  output logic                     sram_write_en,
  output logic [c_data_nbytes-1:0] sram_write_byte_en,
  output logic [c_addr_nbits-1:0]  sram_write_addr,
  output logic [p_data_nbits-1:0]  sram_write_data,
  output logic                     sram_sd
);
  logic [c_addr_nbits-1:0]  index;
  logic [c_off_nbits-1:0]   off;
  logic [c_data_nbytes-1:0] lo_en;
  logic [p_data_nbits-1:0]  rmask, rdata;
  logic                     xfer, full;
  int                       nbytes;
  assign {index, off} = req_addr;
  assign nbytes  = len_to_nbytes(int'(req_len), c_data_nbytes);
  assign req_rdy = !full;
  assign xfer    = req_val && req_rdy && !reset;
  // lo_en marks the low nbytes byte lanes; it masks reads and, shifted, forms write strobes
  always_comb
    for (int i = 0; i < c_data_nbytes; i++) begin
      lo_en[i] = i < nbytes;
      rmask[8*i+:8] = {8{lo_en[i]}};
    end
  assign rdata              = (sram_read_data >> {off, 3'b000}) & rmask;
  assign sram_read_en       = xfer && req_type == VC_MEM_REQ_READ;
  assign sram_write_en      = xfer && req_type == VC_MEM_REQ_WRITE;
  assign sram_read_addr     = index;
  assign sram_write_addr    = index;
  assign sram_write_byte_en = lo_en << off;
  assign sram_write_data    = req_data << {off, 3'b000};
  assign sram_sd            = sd;
  vc_sram_resp_queue_2entry #(.p_msg_nbits(p_data_nbits + 1)) resp_q (
    .clk     (clk),
    .reset   (reset),
    .enq_val (xfer),
    .enq_msg ({req_type, req_type == VC_MEM_REQ_WRITE ? '0 : rdata}),
    .full    (full),
    .deq_val (resp_val),
    .deq_rdy (resp_rdy),
    .deq_msg ({resp_type, resp_data})
  );
  always_ff @(posedge clk)
    if (!reset) begin
      assert (!$isunknown(req_val));
      assert (!$isunknown(resp_rdy));
      assert (!req_val || !$isunknown(req_type));
      assert (!xfer || int'(index) < p_num_entries);
      assert (!xfer || int'(off) + nbytes <= c_data_nbytes);
    end
endmodule

// File: tb/tb_vc_sram_mem_port.sv
// tb_vc_sram_mem_port: directed and random checks of the SRAM port against a byte-array model
module tb_vc_sram_mem_port;
  logic        clk = 0, reset, sd;
  logic        req_val, req_rdy, req_type;
  logic [9:0]  req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_data;
  logic        resp_val, resp_rdy, resp_type;
  logic [31:0] resp_data;
  logic        sram_read_en, sram_write_en, sram_sd;
  logic [7:0]  sram_read_addr, sram_write_addr;
  logic [31:0] sram_read_data, sram_write_data;
  logic [3:0]  sram_write_byte_en;
  logic [31:0] sram [256];
  logic [7:0]  ref_bytes [1024];
  logic [32:0] expq [$];
  int vectors = 0, errs = 0;

  always #5 clk = !clk;

  vc_sram_mem_port dut (
    .clk(clk), .reset(reset), .sd(sd),
    .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_type(resp_type), .resp_data(resp_data),
    .sram_read_en(sram_read_en), .sram_read_addr(sram_read_addr), .sram_read_data(sram_read_data),
    .sram_write_en(sram_write_en), .sram_write_byte_en(sram_write_byte_en),
    .sram_write_addr(sram_write_addr), .sram_write_data(sram_write_data), .sram_sd(sram_sd)
  );

  always_comb sram_read_data = sram[sram_read_addr];
  always @(posedge clk)
    if (sram_write_en)
      for (int i = 0; i < 4; i++)
        if (sram_write_byte_en[i]) sram[sram_write_addr][8*i+:8] <= sram_write_data[8*i+:8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rd_wr_exclusive", 64'(sram_read_en && sram_write_en), 0);
    chk("sd_passthru", 64'(sram_sd), 64'(sd));
    if (!reset && resp_val === 1'b1 && resp_rdy) begin
      if (expq.size() == 0) chk("unexpected_resp", {resp_type, resp_data}, 64'h1_0000_0000_0);
      else chk("resp", {resp_type, resp_data}, expq.pop_front());
    end
  end

  task automatic do_req(input logic t, input logic [9:0] a, input logic [1:0] l, input logic [31:0] d);
    int off, nb, n;
    logic [31:0] ex;
    req_val = 1; req_type = t; req_addr = a; req_len = l; req_data = d;
    #1;
    n = 0;
    while (req_rdy !== 1'b1 && n < 20) begin
      resp_rdy = 1;
      @(posedge clk); #2;
      n++;
    end
    chk("req_rdy_wait", 64'(req_rdy), 1);
    off = int'(a) % 4;
    nb = (l == 0) ? 4 : int'(l);
    chk("rd_en", 64'(sram_read_en), 64'(!t));
    chk("wr_en", 64'(sram_write_en), 64'(t));
    ex = 0;
    if (t) begin
      chk("wr_addr", 64'(sram_write_addr), 64'(a / 4));
      chk("wr_be", 64'(sram_write_byte_en), 64'((((1 << nb) - 1) << off) & 15));
      chk("wr_data", 64'(sram_write_data), 64'(32'(d << (8 * off))));
      for (int b = 0; b < nb; b++) ref_bytes[int'(a) + b] = d[8*b+:8];
    end else begin
      chk("rd_addr", 64'(sram_read_addr), 64'(a / 4));
      for (int b = 0; b < nb; b++) ex |= 32'(ref_bytes[int'(a) + b]) << (8 * b);
    end
    expq.push_back({t, ex});
    @(posedge clk); #1;
    req_val = 0;
  endtask

  initial begin
    logic [9:0] a;
    int nb;
    for (int i = 0; i < 256; i++) sram[i] = 0;
    for (int i = 0; i < 1024; i++) ref_bytes[i] = 0;
    reset = 1; sd = 0; req_val = 0; req_type = 0; req_addr = 0; req_len = 0; req_data = 0; resp_rdy = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset_resp_val", 64'(resp_val), 0);
    chk("reset_req_rdy", 64'(req_rdy), 1);
    sd = 1;
    do_req(1, 10'h10, 0, 32'hdeadbeef);
    chk("wr_resp_latency", 64'(resp_val), 1);
    chk("wr_resp_data", 64'(resp_data), 0);
    do_req(0, 10'h10, 0, 0);
    chk("rd_resp_latency", 64'(resp_val), 1);
    chk("rd_word", 64'(resp_data), 64'h deadbeef);
    do_req(1, 10'h12, 1, 32'h000000ab);
    do_req(0, 10'h10, 0, 0);
    chk("rd_after_byte_wr", 64'(resp_data), 64'h deabbeef);
    do_req(0, 10'h12, 2, 0);
    chk("rd_half", 64'(resp_data), 64'h0000deab);
    do_req(0, 10'h13, 1, 0);
    chk("rd_byte", 64'(resp_data), 64'h000000de);
    sd = 0;
    @(posedge clk); #1;
    resp_rdy = 0;
    do_req(0, 10'h00, 0, 0);
    do_req(0, 10'h04, 0, 0);
    chk("full_req_rdy", 64'(req_rdy), 0);
    chk("full_resp_val", 64'(resp_val), 1);
    resp_rdy = 1;
    do_req(0, 10'h08, 0, 0);
    do_req(0, 10'h0c, 0, 0);
    for (int i = 0; i < 4; i++) begin
      do_req(0, 10'(4 * i), 0, 0);
      chk("stream_resp_val", 64'(resp_val), 1);
      chk("stream_req_rdy", 64'(req_rdy), 1);
    end
    repeat (3) @(posedge clk); #1;
    resp_rdy = 0;
    do_req(1, 10'h20, 0, 32'h12345678);
    do_req(0, 10'h10, 0, 0);
    chk("pre_reset_full", 64'(req_rdy), 0);
    reset = 1; expq.delete();
    req_val = 1; req_type = 1; req_addr = 10'h10; req_len = 0; req_data = 32'hffffffff;
    #1;
    chk("reset_no_wr_en", 64'(sram_write_en), 0);
    chk("reset_no_rd_en", 64'(sram_read_en), 0);
    @(posedge clk); #1;
    reset = 0; req_val = 0;
    chk("midreset_resp_val", 64'(resp_val), 0);
    chk("midreset_req_rdy", 64'(req_rdy), 1);
    resp_rdy = 1;
    do_req(0, 10'h10, 0, 0);
    chk("sram_kept", 64'(resp_data), 64'h deabbeef);
    do_req(0, 10'h20, 0, 0);
    chk("sram_kept_wr", 64'(resp_data), 64'h12345678);
    for (int k = 0; k < 300; k++) begin
      a = 10'($urandom_range(0, 1023));
      nb = $urandom_range(1, 4 - int'(a[1:0]));
      resp_rdy = 1'($urandom);
      sd = 1'($urandom);
      do_req(1'($urandom), a, 2'(nb), $urandom);
    end
    resp_rdy = 1;
    repeat (4) @(posedge clk); #1;
    chk("drain", 64'(expq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/vc_sram_mem_port.md
Name: vc_sram_mem_port

Overview:
- Val/rdy memory-request front end that sits directly upstream of the single-port combinational 1rw SRAM and drives its read and write ports.
- Accepts byte-addressed read/write requests with subword length and converts them into SRAM word accesses with byte enables.
- Returns responses through a 2-entry response queue with a fixed one-cycle minimum latency.
- Carries the security-domain input sd through unchanged to the SRAM.

Parameters:
- p_data_nbits, 32, SRAM word width; must be a multiple of 8 and a power-of-two number of bytes.
- p_num_entries, 256, SRAM word count.
- c_addr_nbits, $clog2(p_num_entries), local: word index width.
- c_data_nbytes, p_data_nbits/8, local: bytes per word.
- c_off_nbits, $clog2(c_data_nbytes), local: byte-offset width; also the width of the len field.
- c_baddr_nbits, c_addr_nbits+c_off_nbits, local: byte address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- sd  in  1  security domain, passed to SRAM sd.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_type  in  1  0=read, 1=write.
- req_addr  in  c_baddr_nbits  byte address.
- req_len  in  c_off_nbits  byte count; 0 means full word.
- req_data  in  p_data_nbits  write data, right-justified.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_type  out  1  echoes req_type.
- resp_data  out  p_data_nbits  read data, right-justified and zero-extended; 0 for writes.
- sram_read_en  out  1  SRAM read enable.
- sram_read_addr  out  c_addr_nbits  SRAM read word index.
- sram_read_data  in  p_data_nbits  SRAM combinational read data.
- sram_write_en  out  1  SRAM write enable.
- sram_write_byte_en  out  c_data_nbytes  SRAM byte enables.
- sram_write_addr  out  c_addr_nbits  SRAM write word index.
- sram_write_data  out  p_data_nbits  SRAM write data.
- sram_sd  out  1  equals sd.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Transfer: a transfer occurs when val && rdy at a posedge.
- req_rdy = !queue_full. It is derived from registered state only; there is no combinational path from resp_rdy.
- Address split: word index = req_addr[c_baddr_nbits-1:c_off_nbits]; off = req_addr[c_off_nbits-1:0]; nbytes = (req_len==0) ? c_data_nbytes : req_len.
- Read, in the transfer cycle:
  - sram_read_en=1, sram_read_addr=index.
  - Response data = (sram_read_data >> 8*off) masked to the low nbytes bytes, remaining bytes zero.
  - The response is enqueued at the same edge.
- Write, in the transfer cycle:
  - sram_write_en=1, sram_write_addr=index.
  - sram_write_data = req_data << 8*off.
  - sram_write_byte_en = ((1<<nbytes)-1) << off, truncated to c_data_nbytes.
  - A response with data 0 is enqueued.
- When no transfer occurs, both enables are 0. read_en and write_en are never asserted together.
- Latency: a request accepted at edge N produces resp_val=1 after edge N; 1 cycle when the queue is empty.
- Response queue:
  - 2 entries, FIFO order, no reordering.
  - Full throughput of one request per cycle while resp_rdy=1.
  - Simultaneous enqueue and dequeue at count 2 is impossible because req_rdy=0.
  - At count 1, enqueue and dequeue together keep the count at 1.
- Byte enables beyond the word boundary (off+nbytes > c_data_nbytes) are dropped; the assertion below flags this case.
- Reset:
  - Queue count=0, resp_val=0, req_rdy=1 in the cycle after reset.
  - Both SRAM enables are 0 while reset=1; requests presented during reset are ignored.
  - Asserting reset mid-stream discards queued responses; SRAM contents are untouched.
- Assertions (checked when !reset):
  - req_val, resp_rdy and req_type (when req_val) are not X.
  - Word index < p_num_entries on transfer.
  - off+nbytes <= c_data_nbytes on transfer.

Decomposition:
- Shared package vc_mem_msg_pkg:
  - Constants VC_MEM_REQ_READ=1'b0 and VC_MEM_REQ_WRITE=1'b1.
  - Macro/function for the len-to-nbytes decode.
- Sub-module vc_sram_resp_queue_2entry: 2-entry val/rdy queue of {type, data}, exposing a full flag.

Test Plan:
- After reset, write addr 0x10, len 0, data 0xdeadbeef, then read 0x10 -> write strobes byte_en 0b1111 at index 4; the write response appears with data 0; the read response appears 1 cycle after acceptance with data 0xdeadbeef.
- Byte write 0xab to addr 0x12 (len 1), then read 0x10 len 0 -> byte_en 0b0100, write_data 0x00ab0000; read returns 0xdeabbeef.
- Halfword read addr 0x12, len 2 -> resp_data 0x0000deab. Byte read 0x13 -> 0x000000de.
- Back-to-back reads of indices 0..3 with resp_rdy=0 -> req_rdy drops after 2 acceptances. Raise resp_rdy -> responses arrive in order. With resp_rdy held 1, one response per cycle.
- Queue 2 responses, assert reset for 1 cycle -> resp_val=0 and req_rdy=1 next cycle; previously written SRAM data is still readable.
- Every cycle of every test: sram_read_en && sram_write_en never both 1.
